// File: rtl/key_event_reg.sv
// key_event_reg: keypad input register.
// Synchronises and debounces NUM_KEYS raw key lines, exposes the lowest
// debounced key number, and queues key events in a small FIFO that the game
// FSM drains over a valid/ready handshake.
//
// Handshake: evt_valid is high whenever the queue holds an entry; the head
// entry (evt_key/evt_release) is consumed on every clock edge where
// evt_valid & evt_ready are both high, and is held steady otherwise.
//
// Build option: define KEY_RELEASE_EVT_EN to also queue release events.
// Without it only presses are queued and evt_release stays 0; the port list
// is the same in both builds.
module key_event_reg #(
  parameter int NUM_KEYS        = 4,
  parameter int KEY_W           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_KEYS-1:0]           pressed,
  output logic [KEY_W-1:0]              key,
  output logic [KEY_W-1:0]              evt_key,
  output logic                          evt_release,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int DBW   = $clog2(DEBOUNCE_CYCLES);
  localparam int ENT_W = KEY_W + 1;   // {release, key}

  // Lowest set index of a key vector; all ones (NO_KEY) when the vector is empty.
  function automatic logic [KEY_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    lowest_idx = '1;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = KEY_W'(i);
    end
  endfunction

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] s_q, s_d;
  logic [NUM_KEYS-1:0] s_prev_q, s_prev_d;
  logic [NUM_KEYS-1:0] stable_q, stable_d;
  logic [DBW-1:0]      cnt_q, cnt_d;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [ENT_W-1:0]    head_q, head_d;

  logic                upd;
  logic [NUM_KEYS-1:0] rise;
  logic                push_req;
  logic [ENT_W-1:0]    push_ent;
  logic                pop, full, drop, push_ok;

  // Synchroniser chain and shared whole-vector debounce counter.
  always_comb begin
    sync1_d  = pressed;
    s_d      = sync1_q;
    s_prev_d = s_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    upd      = 1'b0;
    if (s_q != s_prev_q || s_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = s_q;
      cnt_d    = '0;
      upd      = 1'b1;
    end else begin
      cnt_d = cnt_q + DBW'(1);
    end
  end

  // Event generation on the edge the debounced vector changes; a press wins over a release.
  always_comb begin
    rise     = s_q & ~stable_q;
    push_req = 1'b0;
    push_ent = '0;
    if (upd && rise != '0) begin
      push_req = 1'b1;
      push_ent = {1'b0, lowest_idx(rise)};
    end
`ifdef KEY_RELEASE_EVT_EN
    else if (upd && (~s_q & stable_q) != '0) begin
      push_req = 1'b1;
      push_ent = {1'b1, lowest_idx(~s_q & stable_q)};
    end
`endif
  end

  // Event FIFO: push/pop bookkeeping, sticky overflow, registered head entry.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    pop     = (count_q != '0) && evt_ready;
    full    = (count_q == CW'(FIFO_DEPTH));
    drop    = push_req && full && !pop;
    push_ok = push_req && !drop;
    if (push_ok) begin
      mem_d[wr_q] = push_ent;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) rd_d = rd_q + PTR_W'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop);
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
    head_d = mem_d[rd_d];
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      s_q      <= '0;
      s_prev_q <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      mem_q    <= '{default: '0};
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      s_q      <= s_d;
      s_prev_q <= s_prev_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
    end
  end

  assign key         = lowest_idx(stable_q);
  assign evt_key     = head_q[KEY_W-1:0];
  assign evt_release = head_q[KEY_W];
  assign evt_valid   = (count_q != '0);
  assign evt_count   = count_q;
  assign overflow    = ovf_q;

endmodule
